// File: rtl/exmem_pkg.sv
// Shared types and helpers for the EX->MEM elastic boundary.
// Store funct3 codes, the entry control payload and the base byte-lane mask.
package exmem_pkg;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    typedef struct packed {
        logic [2:0] funct3;
        logic       rdsrc;
        logic       memtoreg;
        logic       memread;
        logic       regwrite;
        logic       misalign;
    } exmem_ctrl_t;

    // Lane mask before shifting by the byte offset; SD only exists on 64-bit datapaths.
    function automatic logic [7:0] byte_mask(input logic [2:0] funct3, input int unsigned xlen);
        logic [7:0] mask;
        mask = 8'h00;
        case (funct3)
            SB:      mask = 8'h01;
            SH:      mask = 8'h03;
            SW:      mask = 8'h0F;
            SD:      mask = (xlen == 64) ? 8'hFF : 8'h00;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/exmem_store_align.sv
// Store lane alignment: active-low byte enables, lane-shifted data and misalign flag.
// Misalign trapping is built only when EXMEM_MISALIGN_TRAP_EN is defined.
module exmem_store_align
    import exmem_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned NB   = XLEN / 8,
    localparam int unsigned OW   = $clog2(NB)
) (
    input  logic [OW-1:0]   off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic            mem_write,
`ifdef EXMEM_MISALIGN_TRAP_EN
    input  logic            mem_read,
`endif
    output logic [NB-1:0]   web_c,
    output logic [XLEN-1:0] data_c,
    output logic            misalign_c
);

    logic [NB-1:0] lanes;

    // Lanes shifted past the top of the word are dropped.
    assign lanes = NB'(NB'(byte_mask(funct3, XLEN)) << off);

`ifdef EXMEM_MISALIGN_TRAP_EN
    logic [2:0] align_mask;
    assign align_mask = 3'((4'd1 << funct3[1:0]) - 4'd1);
    assign misalign_c = (mem_write || mem_read) && (|(3'(off) & align_mask));
`else
    assign misalign_c = 1'b0;
`endif

    assign web_c  = (mem_write && !misalign_c) ? ~lanes : {NB{1'b1}};
    assign data_c = mem_write ? (store_data << {off, 3'b000}) : store_data;

endmodule

// File: rtl/exmem_elastic_reg.sv
// Two-entry (main + skid) elastic EX/MEM register with store lane alignment.
// Optional misalign trap: define EXMEM_MISALIGN_TRAP_EN.
module exmem_elastic_reg
    import exmem_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      ALU_out,
    input  logic [REGADDR_W-1:0] EXE_write_addr,
    input  logic [2:0]           EXE_funct3,
    input  logic [XLEN-1:0]      EXE_pc,
    input  logic [XLEN-1:0]      EXE_memory_in,
    input  logic                 EXE_RDSrc,
    input  logic                 EXE_MemtoReg,
    input  logic                 EXE_MemWrite,
    input  logic                 EXE_MemRead,
    input  logic                 EXE_RegWrite,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      MEM_ALU_out,
    output logic [XLEN-1:0]      MEM_pc,
    output logic [XLEN-1:0]      MEM_memory_in,
    output logic [REGADDR_W-1:0] MEM_write_addr,
    output logic [2:0]           MEM_funct3,
    output logic [XLEN/8-1:0]    MEM_web,
    output logic                 MEM_RDSrc,
    output logic                 MEM_MemtoReg,
    output logic                 MEM_MemRead,
    output logic                 MEM_RegWrite,
    output logic                 MEM_misalign
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    logic [NB-1:0]        in_web;
    logic [XLEN-1:0]      in_data;
    logic                 in_misalign;
    exmem_ctrl_t          in_ctrl;

    logic                 main_valid, main_valid_d;
    logic                 skid_valid, skid_valid_d;
    logic                 in_ready_d;
    logic                 push, pop;

    logic [XLEN-1:0]      m_alu, m_alu_d, s_alu, s_alu_d;
    logic [XLEN-1:0]      m_pc, m_pc_d, s_pc, s_pc_d;
    logic [XLEN-1:0]      m_data, m_data_d, s_data, s_data_d;
    logic [REGADDR_W-1:0] m_waddr, m_waddr_d, s_waddr, s_waddr_d;
    logic [NB-1:0]        m_web, m_web_d, s_web, s_web_d;
    exmem_ctrl_t          m_ctrl, m_ctrl_d, s_ctrl, s_ctrl_d;

    exmem_store_align #(.XLEN(XLEN)) u_align (
        .off        (ALU_out[OW-1:0]),
        .funct3     (EXE_funct3),
        .store_data (EXE_memory_in),
        .mem_write  (EXE_MemWrite),
`ifdef EXMEM_MISALIGN_TRAP_EN
        .mem_read   (EXE_MemRead),
`endif
        .web_c      (in_web),
        .data_c     (in_data),
        .misalign_c (in_misalign)
    );

    always_comb begin
        in_ctrl          = '0;
        in_ctrl.funct3   = EXE_funct3;
        in_ctrl.rdsrc    = EXE_RDSrc;
        in_ctrl.memtoreg = EXE_MemtoReg;
        in_ctrl.memread  = EXE_MemRead;
        in_ctrl.regwrite = EXE_RegWrite && !in_misalign;
        in_ctrl.misalign = in_misalign;
    end

    assign push = in_valid && in_ready;
    assign pop  = main_valid && out_ready;

    // Next-state for both entries; bubbles keep datapath but clear side-effecting controls.
    always_comb begin
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        in_ready_d   = in_ready;
        m_alu_d = m_alu;  m_pc_d = m_pc;  m_data_d = m_data;
        m_waddr_d = m_waddr;  m_web_d = m_web;  m_ctrl_d = m_ctrl;
        s_alu_d = s_alu;  s_pc_d = s_pc;  s_data_d = s_data;
        s_waddr_d = s_waddr;  s_web_d = s_web;  s_ctrl_d = s_ctrl;

        if (flush) begin
            main_valid_d      = 1'b0;
            skid_valid_d      = 1'b0;
            in_ready_d        = 1'b1;
            m_web_d           = {NB{1'b1}};
            m_ctrl_d.regwrite = 1'b0;
            m_ctrl_d.memread  = 1'b0;
            m_ctrl_d.misalign = 1'b0;
        end else if (pop && skid_valid) begin
            m_alu_d = s_alu;  m_pc_d = s_pc;  m_data_d = s_data;
            m_waddr_d = s_waddr;  m_web_d = s_web;  m_ctrl_d = s_ctrl;
            skid_valid_d = 1'b0;
            in_ready_d   = 1'b1;
        end else if (push && (!main_valid || pop)) begin
            m_alu_d = ALU_out;  m_pc_d = EXE_pc;  m_data_d = in_data;
            m_waddr_d = EXE_write_addr;  m_web_d = in_web;  m_ctrl_d = in_ctrl;
            main_valid_d = 1'b1;
        end else if (push) begin
            s_alu_d = ALU_out;  s_pc_d = EXE_pc;  s_data_d = in_data;
            s_waddr_d = EXE_write_addr;  s_web_d = in_web;  s_ctrl_d = in_ctrl;
            skid_valid_d = 1'b1;
            in_ready_d   = 1'b0;
        end else if (pop) begin
            main_valid_d      = 1'b0;
            m_web_d           = {NB{1'b1}};
            m_ctrl_d.regwrite = 1'b0;
            m_ctrl_d.memread  = 1'b0;
            m_ctrl_d.misalign = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            m_alu <= '0;  m_pc <= '0;  m_data <= '0;
            m_waddr <= '0;  m_web <= {NB{1'b1}};  m_ctrl <= '0;
            s_alu <= '0;  s_pc <= '0;  s_data <= '0;
            s_waddr <= '0;  s_web <= {NB{1'b1}};  s_ctrl <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            in_ready   <= in_ready_d;
            m_alu <= m_alu_d;  m_pc <= m_pc_d;  m_data <= m_data_d;
            m_waddr <= m_waddr_d;  m_web <= m_web_d;  m_ctrl <= m_ctrl_d;
            s_alu <= s_alu_d;  s_pc <= s_pc_d;  s_data <= s_data_d;
            s_waddr <= s_waddr_d;  s_web <= s_web_d;  s_ctrl <= s_ctrl_d;
        end
    end

    assign out_valid      = main_valid;
    assign MEM_ALU_out    = m_alu;
    assign MEM_pc         = m_pc;
    assign MEM_memory_in  = m_data;
    assign MEM_write_addr = m_waddr;
    assign MEM_funct3     = m_ctrl.funct3;
    assign MEM_web        = m_web;
    assign MEM_RDSrc      = m_ctrl.rdsrc;
    assign MEM_MemtoReg   = m_ctrl.memtoreg;
    assign MEM_MemRead    = m_ctrl.memread;
    assign MEM_RegWrite   = m_ctrl.regwrite;
    assign MEM_misalign   = m_ctrl.misalign;

endmodule
